// File: rtl/mil_push_arbiter_if.sv
// Bundle between N_REQ requesters, the push arbiter and one IPushMil-style transmitter.
// Handshake: req_request/req_done and push_request/push_done are one-cycle pulses; type/data stay stable from request until the matching done.
interface mil_push_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_request;
  logic [2*N_REQ-1:0]  req_type;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_done;
  logic                push_request;
  logic [1:0]          push_type;
  logic [15:0]         push_data;
  logic                push_done;
  logic [N_REQ-1:0]    grant;
  logic                busy;
  logic                timeout_err;
  logic                overrun_err;

  // Requesters plus transmitter side.
  modport master (
    output req_request, req_type, req_data, push_done,
    input  req_done, push_request, push_type, push_data, grant, busy, timeout_err, overrun_err
  );

  // Arbiter side.
  modport slave (
    input  req_request, req_type, req_data, push_done,
    output req_done, push_request, push_type, push_data, grant, busy, timeout_err, overrun_err
  );
endinterface

// File: rtl/mil_push_arbiter.sv
// Round-robin arbiter sharing one MIL push port between N_REQ requesters.
// One word in flight at a time; a watchdog aborts words whose done never returns.
module mil_push_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  mil_push_arbiter_if.slave  bus,
  output logic [1:0]         dbg_state
);
  localparam int PW  = $clog2(N_REQ);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             abort_q, abort_d;
  logic             overrun_q, overrun_d;

  logic             pick_found;
  logic [PW-1:0]    pick_idx;

  // First pending slot at or after rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!pick_found && pending_q[j]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    wdog_d           = wdog_q;
    abort_d          = abort_q;
    pending_d        = pending_q | (bus.req_request & ~pending_q);
    overrun_d        = |(bus.req_request & pending_q);
    bus.push_request = 1'b0;
    bus.push_type    = '0;
    bus.push_data    = '0;
    bus.timeout_err  = 1'b0;
    bus.req_done     = '0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d             = pick_idx;
          grant_d             = '0;
          grant_d[pick_idx]   = 1'b1;
          pending_d[pick_idx] = 1'b0;
          state_d             = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.push_request = 1'b1;
        bus.push_type    = bus.req_type[2*int'(owner_q) +: 2];
        bus.push_data    = bus.req_data[16*int'(owner_q) +: 16];
        wdog_d           = '0;
        abort_d          = 1'b0;
        state_d          = S_WAIT;
      end
      S_WAIT: begin
        bus.push_type = bus.req_type[2*int'(owner_q) +: 2];
        bus.push_data = bus.req_data[16*int'(owner_q) +: 16];
        wdog_d        = wdog_q + 1'b1;
        // A done on the watchdog's last cycle still wins over the abort.
        if (bus.push_done) begin
          state_d = S_DONE;
        end else if (TIMEOUT != 0 && wdog_q == WDOG_LAST) begin
          bus.timeout_err = 1'b1;
          abort_d         = 1'b1;
          state_d         = S_DONE;
        end
      end
      S_DONE: begin
        if (!abort_q) bus.req_done[owner_q] = 1'b1;
        rr_ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        grant_d  = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      pending_q <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      wdog_q    <= '0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      wdog_q    <= wdog_d;
      abort_q   <= abort_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.overrun_err = overrun_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_mil_push_arbiter.sv
// Bench for mil_push_arbiter: transaction-level model checked every cycle plus directed scenario checks.
module tb_mil_push_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  mil_push_arbiter_if #(.N_REQ(N)) bus();

  mil_push_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rd[N];
  logic [1:0]  rt[N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.req_data[16*i +: 16] = rd[i];
      bus.req_type[2*i +: 2]   = rt[i];
    end
  end

  // ---------------- bookkeeping ----------------
  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;
  int  done_cnt[N];
  int  pr_cnt, tmo_cnt, ovr_cnt;
  int  last_pr_cyc, last_pd_cyc, last_done_cyc, last_tmo_cyc, req_cyc;
  logic [15:0]  last_pr_data;
  logic [N-1:0] last_pr_grant;
  logic [7:0]   exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    pr_cnt = 0; tmo_cnt = 0; ovr_cnt = 0;
    last_pr_cyc = -1; last_pd_cyc = -1; last_done_cyc = -1; last_tmo_cyc = -1;
  endtask

  // ---------------- behavioural model ----------------
  // Word life: age 0 is the push_request cycle, age k is k cycles later; a closing cycle follows done/abort.
  bit m_pend[N];
  int m_rr = 0;
  int m_owner = -1;
  int m_age = 0;
  bit m_closing = 0, m_abort = 0, m_ovr = 0;
  bit o_pend[N];
  bit nov;
  int sel;

  logic [N-1:0] e_grant, e_done;
  logic         e_pr, e_busy, e_tmo;
  logic [1:0]   e_type;
  logic [15:0]  e_data;
  logic [7:0]   g_idx, g_exp;

  initial begin
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
  end

  // ---------------- per-cycle compare + monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_grant = '0; e_done = '0; e_pr = 0; e_busy = 0; e_tmo = 0; e_type = '0; e_data = '0;
        if (m_owner >= 0) begin
          e_grant[m_owner] = 1'b1;
          e_busy = 1'b1;
          if (m_closing) begin
            e_done[m_owner] = !m_abort;
          end else begin
            e_pr   = (m_age == 0);
            e_type = rt[m_owner];
            e_data = rd[m_owner];
            e_tmo  = (m_age == TMO) && !bus.push_done;
          end
        end
        chk("grant", 32'(bus.grant), 32'(e_grant));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("push_request", 32'(bus.push_request), 32'(e_pr));
        chk("push_type", 32'(bus.push_type), 32'(e_type));
        chk("push_data", 32'(bus.push_data), 32'(e_data));
        chk("req_done", 32'(bus.req_done), 32'(e_done));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e_tmo));
        chk("overrun_err", 32'(bus.overrun_err), 32'(m_ovr));

        // event log for the directed checks
        if (bus.push_request === 1'b1) begin
          pr_cnt++;
          last_pr_cyc   = cyc;
          last_pr_data  = bus.push_data;
          last_pr_grant = bus.grant;
          g_idx = 8'hFF;
          for (int i = 0; i < N; i++) if (bus.grant[i]) g_idx = 8'(i);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_order: got owner %0d expected no grant (cycle %0d)", g_idx, cyc);
          end else begin
            g_exp = exp_q.pop_front();
            chk("grant_order", 32'(g_idx), 32'(g_exp));
          end
        end
        if (bus.push_done === 1'b1) last_pd_cyc = cyc;
        for (int i = 0; i < N; i++) begin
          if (bus.req_done[i] === 1'b1) begin
            done_cnt[i]++;
            last_done_cyc = cyc;
          end
        end
        if (bus.timeout_err === 1'b1) begin tmo_cnt++; last_tmo_cyc = cyc; end
        if (bus.overrun_err === 1'b1) ovr_cnt++;

        // advance model across the coming edge
        if (rst) begin
          for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
          m_rr = 0; m_owner = -1; m_age = 0; m_closing = 0; m_abort = 0; m_ovr = 0;
        end else begin
          nov = 0;
          for (int i = 0; i < N; i++) o_pend[i] = m_pend[i];
          for (int i = 0; i < N; i++) begin
            if (bus.req_request[i]) begin
              if (o_pend[i]) nov = 1;
              else m_pend[i] = 1'b1;
            end
          end
          if (m_owner < 0) begin
            sel = -1;
            for (int k = 0; k < N; k++) begin
              if (sel < 0 && o_pend[(m_rr + k) % N]) sel = (m_rr + k) % N;
            end
            if (sel >= 0) begin
              m_owner = sel; m_age = 0; m_closing = 0; m_pend[sel] = 1'b0;
            end
          end else if (m_closing) begin
            m_rr = (m_owner + 1) % N; m_owner = -1; m_closing = 0;
          end else if (m_age == 0) begin
            m_age = 1;
          end else if (bus.push_done) begin
            m_closing = 1; m_abort = 0;
          end else if (m_age == TMO) begin
            m_closing = 1; m_abort = 1;
          end else begin
            m_age++;
          end
          m_ovr = nov;
        end
      end
    end
  end

  // ---------------- transmitter responder ----------------
  int resp_delay = 3;
  int resp_cnt = 0;
  bit resp_en = 1'b1;
  initial begin
    bus.push_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.push_request === 1'b1 && resp_en) resp_cnt = resp_delay;
      @(posedge clk);
      #1;
      bus.push_done = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) bus.push_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    bus.req_request = m;
    req_cyc = cyc;
    tick();
    bus.req_request = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic wait_quiet(input int budget, input string nm);
    int n;
    bit quiet;
    n = 0;
    quiet = 0;
    while (!quiet && n < budget) begin
      tick();
      n++;
      quiet = (m_owner < 0);
      for (int i = 0; i < N; i++) if (m_pend[i]) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL %s: arbiter still active after %0d cycles, expected idle", nm, budget);
    end
    tick();
  endtask

  task automatic wait_pr(input int cnt, input int budget, input string nm);
    int n;
    n = 0;
    while (pr_cnt < cnt && n < budget) begin tick(); n++; end
    checks++;
    if (pr_cnt < cnt) begin
      errors++;
      $display("FAIL %s: push_request count %0d expected %0d", nm, pr_cnt, cnt);
    end
  endtask

  task automatic wait_tmo(input int budget, input string nm);
    int n;
    n = 0;
    while (tmo_cnt < 1 && n < budget) begin tick(); n++; end
    checks++;
    if (tmo_cnt < 1) begin
      errors++;
      $display("FAIL %s: timeout_err count %0d expected 1", nm, tmo_cnt);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.req_request = '0;
    for (int i = 0; i < N; i++) begin rd[i] = '0; rt[i] = '0; end
    clear_stats();
    tick();
    chk_en = 1'b1;
    do_reset();

    // reset state
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_req_done", 32'(bus.req_done), 32'h0);
    chk("rst_push_request", 32'(bus.push_request), 32'h0);
    chk("rst_push_data", 32'(bus.push_data), 32'h0);

    // single word
    rd[2] = 16'hA5A5; rt[2] = 2'd0; resp_delay = 5; resp_en = 1;
    exp_q.push_back(8'd2);
    pulse(4'b0100);
    wait_quiet(60, "single_idle");
    chk("single_grant", 32'(last_pr_grant), 32'h4);
    chk("single_data", 32'(last_pr_data), 32'hA5A5);
    chk("single_pr_latency", 32'(last_pr_cyc - req_cyc), 32'd2);
    chk("single_pd_delay", 32'(last_pd_cyc - last_pr_cyc), 32'd5);
    chk("single_done_latency", 32'(last_done_cyc - last_pd_cyc), 32'd1);
    chk("single_done_cnt", 32'(done_cnt[2]), 32'd1);

    // round robin with all four pending
    do_reset();
    rd[0] = 16'h1111; rd[1] = 16'h2222; rd[2] = 16'h3333; rd[3] = 16'h4444;
    rt[0] = 2'd1; rt[1] = 2'd2; rt[2] = 2'd3; rt[3] = 2'd0;
    resp_delay = 3;
    for (int i = 0; i < N; i++) exp_q.push_back(8'(i));
    pulse(4'b1111);
    wait_quiet(100, "rr_idle");
    for (int i = 0; i < N; i++) chk($sformatf("rr_done_cnt%0d", i), 32'(done_cnt[i]), 32'd1);
    chk("rr_pr_cnt", 32'(pr_cnt), 32'd4);

    // fairness: owner re-requests while in flight, req1 must go next
    do_reset();
    resp_delay = 6;
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    pulse(4'b0001);
    wait_pr(1, 10, "fair_first_grant");
    pulse(4'b0011);
    wait_quiet(100, "fair_idle");
    chk("fair_done0", 32'(done_cnt[0]), 32'd2);
    chk("fair_done1", 32'(done_cnt[1]), 32'd1);
    chk("fair_overrun", 32'(ovr_cnt), 32'd0);

    // timeout: req1 never answered, req3 then served
    do_reset();
    rd[1] = 16'hBEEF; rd[3] = 16'hCAFE;
    resp_en = 0; resp_delay = 4;
    exp_q.push_back(8'd1); exp_q.push_back(8'd3);
    pulse(4'b1010);
    wait_tmo(40, "tmo_pulse");
    resp_en = 1;
    chk("tmo_delay", 32'(last_tmo_cyc - last_pr_cyc), 32'd16);
    wait_quiet(60, "tmo_idle");
    chk("tmo_done1", 32'(done_cnt[1]), 32'd0);
    chk("tmo_done3", 32'(done_cnt[3]), 32'd1);
    chk("tmo_cnt", 32'(tmo_cnt), 32'd1);

    // done on the watchdog's last cycle counts as done
    do_reset();
    resp_delay = 16;
    exp_q.push_back(8'd2);
    pulse(4'b0100);
    wait_quiet(80, "edge_idle");
    chk("edge_pd_delay", 32'(last_pd_cyc - last_pr_cyc), 32'd16);
    chk("edge_tmo_cnt", 32'(tmo_cnt), 32'd0);
    chk("edge_done2", 32'(done_cnt[2]), 32'd1);

    // overrun: req1 pulses twice while req0 in flight
    do_reset();
    resp_delay = 8;
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0010);
    wait_quiet(80, "ovr_idle");
    chk("ovr_cnt", 32'(ovr_cnt), 32'd1);
    chk("ovr_done0", 32'(done_cnt[0]), 32'd1);
    chk("ovr_done1", 32'(done_cnt[1]), 32'd1);

    // reset during WAIT, then a late push_done
    do_reset();
    resp_delay = 6;
    exp_q.push_back(8'd2);
    pulse(4'b0100);
    wait_pr(1, 10, "rstmid_grant");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rstmid_done2", 32'(done_cnt[2]), 32'd0);
    chk("rstmid_grant", 32'(bus.grant), 32'h0);
    chk("rstmid_busy", 32'(bus.busy), 32'h0);
    chk("rstmid_push_request", 32'(bus.push_request), 32'h0);
    chk("rstmid_pd_seen", 32'(last_pd_cyc > last_pr_cyc), 32'd1);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
